// File: rtl/outport_vc_arbiter.sv
// Per-output-port VC scheduler: round-robin fill of the polarity VC, drain of the opposite VC.
// Optional OUTPORT_HOP_SHIFT_EN: hop field [55:48] is shifted right by one on load.
module outport_vc_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          polarity_i,
  input  logic [NUM_REQ-1:0]            req_vld_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_gnt_o,
  output logic                          so_o,
  input  logic                          ro_i,
  output logic [DATA_WIDTH-1:0]         do_o,
  output logic [1:0]                    vc_full_o
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned VC_BIT = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] vc_data_q [2];
  logic [1:0]            vc_full_q;
  logic [PTR_W-1:0]      rr_ptr_q  [2];

  logic                  fill_vc;
  logic                  drain_vc;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_vld;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      rr_ptr_d;
  logic [DATA_WIDTH-1:0] win_data;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  drain_fire;

  assign fill_vc  = polarity_i;
  assign drain_vc = ~polarity_i;

  // Requesters whose VC bit matches the fill phase, while the fill register has room
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      elig[i] = req_vld_i[i] && (req_data_i[i*DATA_WIDTH + VC_BIT] == fill_vc) &&
                !vc_full_q[fill_vc] && !reset;
    end
  end

  // Round-robin search starting at the fill VC's pointer
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q[fill_vc]) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
    gnt      = gnt_vld ? (NUM_REQ'(1) << win_idx) : '0;
    rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
    load_data = win_data;
`ifdef OUTPORT_HOP_SHIFT_EN
    load_data[55:48] = {1'b0, win_data[55:49]};
`endif
  end

  assign so_o       = vc_full_q[drain_vc] && !reset;
  assign do_o       = so_o ? vc_data_q[drain_vc] : '0;
  assign drain_fire = so_o && ro_i;

  // Fill and drain always address different VCs, so no register sees load and clear together
  always_ff @(posedge clk) begin
    if (reset) begin
      vc_full_q    <= '0;
      vc_data_q[0] <= '0;
      vc_data_q[1] <= '0;
      rr_ptr_q[0]  <= '0;
      rr_ptr_q[1]  <= '0;
    end else begin
      if (gnt_vld) begin
        vc_data_q[fill_vc] <= load_data;
        vc_full_q[fill_vc] <= 1'b1;
        rr_ptr_q[fill_vc]  <= rr_ptr_d;
      end
      if (drain_fire) vc_full_q[drain_vc] <= 1'b0;
    end
  end

  assign req_gnt_o = gnt;
  assign vc_full_o = vc_full_q;

endmodule

// File: tb/tb_outport_vc_arbiter.sv
// Directed bench for outport_vc_arbiter: reset, single packet, round-robin, VC split,
// backpressure, mid-run reset and wrong-VC cases; polarity toggles every cycle.
module tb_outport_vc_arbiter;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic [4:0]  req_vld;
  logic [63:0] rd [5];
  logic [319:0] req_data;
  logic [4:0]  req_gnt;
  logic        so;
  logic        ro;
  logic [63:0] dout;
  logic [1:0]  vc_full;

  int total = 0;
  int bad   = 0;

`ifdef OUTPORT_HOP_SHIFT_EN
  localparam logic [63:0] SINGLE_EXP = 64'h0008_0201_AAAA_AAAA;
`else
  localparam logic [63:0] SINGLE_EXP = 64'h0011_0201_AAAA_AAAA;
`endif

  outport_vc_arbiter #(.DATA_WIDTH(64), .NUM_REQ(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .polarity_i (polarity),
    .req_vld_i  (req_vld),
    .req_data_i (req_data),
    .req_gnt_o  (req_gnt),
    .so_o       (so),
    .ro_i       (ro),
    .do_o       (dout),
    .vc_full_o  (vc_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 5; i++) req_data[i*64 +: 64] = rd[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; polarity = 1'b0; req_vld = '0; ro = 1'b0;
    for (int i = 0; i < 5; i++) rd[i] = '0;
    tick(); tick();

    // Reset state, with a request pending
    rd[0] = 64'h0000_0000_0000_0001; req_vld = 5'b00001;
    #1;
    chk("rst_gnt", 64'(req_gnt), 64'h0);
    chk("rst_full", 64'(vc_full), 64'h0);
    chk("rst_so", 64'(so), 64'h0);
    chk("rst_do", dout, 64'h0);
    reset = 1'b0; req_vld = '0;

    // Single packet (polarity 0)
    rd[0] = 64'h0011_0201_AAAA_AAAA; req_vld = 5'b00001; ro = 1'b1;
    #1 chk("single_gnt", 64'(req_gnt), 64'h1);
    tick(); req_vld = '0;
    #1;
    chk("single_so", 64'(so), 64'h1);
    chk("single_do", dout, SINGLE_EXP);
    chk("single_full", 64'(vc_full), 64'h1);
    tick();
    #1;
    chk("single_so_off", 64'(so), 64'h0);
    chk("single_empty", 64'(vc_full), 64'h0);

    // Round-robin from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < 5; i++) rd[i] = 64'h100 + 64'(i);
    req_vld = 5'b11111;
    for (int s = 0; s < 6; s++) begin
      int e;
      e = s % 5;
      #1 chk("rr_gnt", 64'(req_gnt), 64'(5'b00001 << e));
      tick();
      #1;
      chk("rr_so", 64'(so), 64'h1);
      chk("rr_do", dout, 64'h100 + 64'(e));
      chk("rr_gnt_odd", 64'(req_gnt), 64'h0);
      tick();
    end

    // VC separation: req1 on VC1, req2 on VC0 (VC0 pointer is at 1)
    req_vld = '0;
    rd[1] = 64'h8000_0000_0000_0011; rd[2] = 64'h0000_0000_0000_0022;
    req_vld = 5'b00110;
    #1 chk("sep_gnt0", 64'(req_gnt), 64'b00100);
    tick(); req_vld = 5'b00010;
    #1;
    chk("sep_gnt1", 64'(req_gnt), 64'b00010);
    chk("sep_so_a", 64'(so), 64'h1);
    chk("sep_do_a", dout, 64'h22);
    tick(); req_vld = '0;
    #1;
    chk("sep_so_b", 64'(so), 64'h1);
    chk("sep_do_b", dout, 64'h8000_0000_0000_0011);
    chk("sep_full_b", 64'(vc_full), 64'b10);
    tick();
    #1;
    chk("sep_so_off", 64'(so), 64'h0);
    chk("sep_empty", 64'(vc_full), 64'h0);
    tick();

    // Backpressure on VC0 (VC0 pointer is at 3)
    rd[3] = 64'h33; req_vld = 5'b01000; ro = 1'b0;
    #1 chk("bp_gnt_first", 64'(req_gnt), 64'b01000);
    tick(); rd[4] = 64'h44; req_vld = 5'b10000;
    #1;
    chk("bp_so0", 64'(so), 64'h1);
    chk("bp_do0", dout, 64'h33);
    chk("bp_gnt_odd", 64'(req_gnt), 64'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      if (polarity == 1'b0) begin
        chk("bp_gnt_blocked", 64'(req_gnt), 64'h0);
        chk("bp_so_even", 64'(so), 64'h0);
      end else begin
        chk("bp_so_odd", 64'(so), 64'h1);
        chk("bp_do_hold", dout, 64'h33);
      end
    end
    ro = 1'b1;
    #1 chk("bp_so_rel", 64'(so), 64'h1);
    tick();
    #1;
    chk("bp_full_clr", 64'(vc_full), 64'h0);
    chk("bp_gnt_next", 64'(req_gnt), 64'b10000);
    tick(); req_vld = '0;
    #1;
    chk("bp_so_next", 64'(so), 64'h1);
    chk("bp_do_next", dout, 64'h44);
    tick();

    // Reset mid-operation with both VC registers full
    rd[0] = 64'h50; req_vld = 5'b00001; ro = 1'b0;
    #1 chk("mr_gnt0", 64'(req_gnt), 64'b00001);
    tick(); rd[1] = 64'h8000_0000_0000_0061; req_vld = 5'b00010;
    #1 chk("mr_gnt1", 64'(req_gnt), 64'b00010);
    tick(); req_vld = '0;
    #1;
    chk("mr_full", 64'(vc_full), 64'b11);
    chk("mr_so", 64'(so), 64'h1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    #1;
    chk("mr_full_clr", 64'(vc_full), 64'h0);
    chk("mr_so_clr", 64'(so), 64'h0);
    chk("mr_do_clr", dout, 64'h0);
    chk("mr_gnt_clr", 64'(req_gnt), 64'h0);
    for (int i = 0; i < 5; i++) rd[i] = 64'h8000_0000_0000_0080 + 64'(i);
    req_vld = 5'b11111; ro = 1'b1;
    #1 chk("mr_restart1", 64'(req_gnt), 64'b00001);
    tick(); req_vld = '0;
    for (int i = 0; i < 5; i++) rd[i] = 64'h90 + 64'(i);
    req_vld = 5'b11111;
    #1;
    chk("mr_restart0", 64'(req_gnt), 64'b00001);
    chk("mr_so_vc1", 64'(so), 64'h1);
    chk("mr_do_vc1", dout, 64'h8000_0000_0000_0080);
    tick(); req_vld = '0;
    #1;
    chk("mr_full_vc0", 64'(vc_full), 64'b01);
    chk("mr_do_vc0", dout, 64'h90);
    tick();
    #1 chk("mr_empty", 64'(vc_full), 64'h0);

    // Wrong-VC and empty requests
    rd[3] = 64'h8000_0000_0000_00A3; req_vld = 5'b01000;
    #1 chk("wv_gnt", 64'(req_gnt), 64'h0);
    tick();
    #1;
    chk("wv_full", 64'(vc_full), 64'h0);
    chk("wv_gnt_phase", 64'(req_gnt), 64'b01000);
    tick(); req_vld = '0;
    #1;
    chk("empty_gnt", 64'(req_gnt), 64'h0);
    chk("wv_full_vc1", 64'(vc_full), 64'b10);
    chk("wv_do", dout, 64'h8000_0000_0000_00A3);
    tick();
    #1 chk("wv_empty", 64'(vc_full), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/outport_vc_arbiter.md
# outport_vc_arbiter

Per-output-port scheduler for the mesh router. It shares one outgoing link among up to NUM_REQ input buffers: the four neighbour inputs plus the PE input. It holds one single-entry output register per virtual channel (VC0/VC1). It arbitrates round-robin into the VC selected by the router `polarity` phase and drains the opposite VC onto the link with the `so`/`ro` handshake. The router instantiates one per output direction: east, west, north, south and PE.

## Interface
- `DATA_WIDTH`, 64, packet width; bit 63 = VC bit, bits 55:48 = hop field.
- `NUM_REQ`, 5, number of requesting input buffers; indices 0..NUM_REQ-1.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `polarity`  in  1  router phase, toggles every cycle; supplied externally and never generated here.
- `req_vld`  in  NUM_REQ  requester i has a packet for this output.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packet of requester i, held in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_gnt`  out  NUM_REQ  one-hot combinational grant; the requester pops its packet at the same edge.
- `so`  out  1  send-out valid on the link.
- `ro`  in  1  downstream ready.
- `do`  out  DATA_WIDTH  link data.
- `vc_full`  out  2  occupancy of the VC0 and VC1 output registers.

## Operation
- Fill VC = `polarity`. Drain VC = `~polarity`. The two VCs never fill and drain in the same cycle.
- Eligible requester i: `req_vld[i]`, `req_data[i][63] == polarity`, and `vc_full[polarity] == 0`.
- Each VC has its own round-robin pointer `rr_ptr[v]` (0..NUM_REQ-1).
  - Search starts at `rr_ptr[v]` and wraps at NUM_REQ-1 → 0.
  - The first eligible requester wins and gets `req_gnt`.
- On the edge with a grant:
  - The winner's packet loads into register[polarity].
  - `vc_full[polarity]` is set.
  - `rr_ptr[polarity]` becomes winner+1 mod NUM_REQ.
  - `rr_ptr` is unchanged when there is no grant.
- Drain: `so = vc_full[~polarity]`; `do = so ? register[~polarity] : 0`.
  - On an edge with `so && ro`, `vc_full[~polarity]` clears.
  - If `ro` is low, the packet stays and the register keeps blocking grants for that VC.
- `req_gnt` is all-zero when `reset` is high, when no requester is eligible, or when the fill register is full.
- Packet contents are unchanged except as noted under Configuration.

## Timing
- Reset values: `req_gnt`=0, `so`=0, `do`=0, `vc_full`=2'b00, both `rr_ptr`=0.
- Register contents reset to 0.
- Reset mid-operation discards buffered packets. No grant is issued during any cycle with `reset`=1.
- Latency:
  - Grant in cycle n (polarity=p); the packet is registered at the end of cycle n.
  - `so`=1 in cycle n+1 (polarity=~p). It leaves at the end of n+1 if `ro`=1.
  - Best-case throughput is one packet per VC every 2 cycles, so the link carries one packet per cycle.
- If `ro` is low in the drain cycle, the next drain opportunity for that VC is 2 cycles later.
- When a register is full and stalled, its drain attempts repeat every other cycle.
- A VC's fill and drain never coincide, so there is no simultaneous load/clear on one register.
- Requesters with the wrong VC bit are ignored this cycle and served in the opposite phase.

## Configuration
- `OUTPORT_HOP_SHIFT_EN`:
  - Defined: on load, hop field bits 55:48 are stored right-shifted by 1, with a 0 shifted into bit 55. All other bits pass unchanged.
  - Undefined: packets are stored and forwarded bit-exact.

## Test plan
- Reset then single packet: polarity=0 in cycle n; `req_vld`=5'b00001, req_data[0]=64'h0011_0201_AAAA_AAAA (VC0), `ro`=1.
  - Cycle n: `req_gnt`=5'b00001.
  - Cycle n+1: `so`=1, `do`=64'h0011_0201_AAAA_AAAA. With `OUTPORT_HOP_SHIFT_EN`, `do`=64'h0008_0201_AAAA_AAAA.
  - Cycle n+2: `so`=0.
- Round-robin: all 5 requesters hold VC0 packets, `ro`=1.
  - Grants on consecutive polarity=0 cycles are 0,1,2,3,4,0.
  - `rr_ptr[0]` wraps from 4 to 0.
- VC separation: requester 1 holds a VC1 packet, requester 2 a VC0 packet.
  - Requester 2 is granted only when polarity=0; requester 1 only when polarity=1.
  - Both packets appear on `do` in back-to-back cycles.
- Backpressure: VC0 register full and `ro`=0 for 6 cycles.
  - `so` pulses on every polarity=1 cycle and `do` holds the same packet.
  - No VC0 grant occurs while full.
  - After `ro`=1, the packet drains and the next VC0 grant follows on the next polarity=0 cycle.
- Reset mid-operation: both VC registers full, `reset`=1 for one cycle.
  - Next cycle: `vc_full`=0, `so`=0, `do`=0, `req_gnt`=0.
  - Arbitration restarts from requester 0.
- Wrong-VC/empty: `req_vld`=0 or only wrong-VC requesters present → `req_gnt`=0 and `vc_full` unchanged.
